store_buffer: RTL and testbench

Parametrised store buffer between the commit stage's data-write port and the data memory write path. It replaces the fixed external data FIFO with an in-core circular queue of committed stores. The queue drains in order over a valid/ready bus. Every cycle it answers a combinational load lookup from execute, forwarding the youngest store data or flagging a partial overlap so execute stalls.

---
 rtl/store_buffer_pkg.sv | 36 +++
 rtl/sb_entry_match.sv | 29 ++
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and helpers for the store buffer.
//   - SB_SIZE_*     : access size encodings (byte/half/word; 3 behaves as word)
//   - sb_entry_t    : one queued store {addr, val, size}
//   - sb_byte_mask  : byte-enable mask of an access within its 32-bit word
//   - sb_lane_align : move a right-justified value onto its byte lanes
package store_buffer_pkg;

    localparam logic [1:0] SB_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SB_SIZE_HALF = 2'd1;
    localparam logic [1:0] SB_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] val;
        logic [1:0]  size;
    } sb_entry_t;

    // Mask is shifted then truncated to 4 bits, so a misaligned access is
    // clipped at the end of its word rather than spilling into the next one.
    function automatic logic [3:0] sb_byte_mask(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] base;
        case (size)
            SB_SIZE_BYTE: base = 4'b0001;
            SB_SIZE_HALF: base = 4'b0011;
            default:      base = 4'b1111;
        endcase
        return base << addr_lo;
    endfunction

    function automatic logic [31:0] sb_lane_align(input logic [31:0] val,
                                                  input logic [1:0]  addr_lo);
        return val << {addr_lo, 3'b000};
    endfunction

endpackage

// File: rtl/sb_entry_match.sv
// sb_entry_match: combinational compare of one store candidate against a load.
//   i_valid     : candidate holds a live store
//   i_entry     : the store {addr, val, size}
//   i_ld_word   : load address bits [31:2]
//   i_ld_mask   : load byte mask
//   o_overlap   : same word and at least one shared byte
//   o_cover     : store mask contains every load byte
//   o_lane_data : store value placed on its byte lanes
module sb_entry_match
    import store_buffer_pkg::*;
(
    input  logic        i_valid,
    input  sb_entry_t   i_entry,
    input  logic [29:0] i_ld_word,
    input  logic [3:0]  i_ld_mask,
    output logic        o_overlap,
    output logic        o_cover,
    output logic [31:0] o_lane_data
);

    logic [3:0] w_st_mask;

    assign w_st_mask   = sb_byte_mask(i_entry.size, i_entry.addr[1:0]);
    assign o_overlap   = i_valid && (i_entry.addr[31:2] == i_ld_word)
                         && ((w_st_mask & i_ld_mask) != 4'b0000);
    assign o_cover     = ((w_st_mask & i_ld_mask) == i_ld_mask);
    assign o_lane_data = sb_lane_align(i_entry.val, i_entry.addr[1:0]);

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular queue of committed stores draining in order to memory,
// with a zero-latency load lookup that forwards from the youngest overlapping
// store or flags a partial overlap.
//   clk, reset                  : clock, async active-high reset
//   datafifo_*                  : enqueue side from commit; datafifo_full = count==DEPTH
//   mem_wr_*                    : drain side, head entry with valid/ready
//   lookup_addr/size/valid      : load probe from execute
//   lookup_hit/data/conflict    : forward result or stall request
//   empty, count                : occupancy
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  bit FWD_EN = 1'b1,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   datafifo_addr_in,
    input  logic [31:0]   datafifo_val_in,
    input  logic [1:0]    datafifo_size_in,
    input  logic          datafifo_valid_in,
    output logic          datafifo_full,
    output logic [31:0]   mem_wr_addr,
    output logic [31:0]   mem_wr_data,
    output logic [1:0]    mem_wr_size,
    output logic          mem_wr_valid,
    input  logic          mem_wr_ready,
    input  logic [31:0]   lookup_addr,
    input  logic [1:0]    lookup_size,
    input  logic          lookup_valid,
    output logic          lookup_hit,
    output logic [31:0]   lookup_data,
    output logic          lookup_conflict,
    output logic          empty,
    output logic [CW-1:0] count
);

    sb_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    sb_entry_t   w_in;
    logic        w_push, w_pop;
    logic [3:0]  w_ld_mask;
    logic [DEPTH:0] w_ovl, w_cov;
    logic [31:0] w_lane [DEPTH+1];

    assign w_in          = '{addr: datafifo_addr_in, val: datafifo_val_in, size: datafifo_size_in};
    assign datafifo_full = (r_count == CW'(DEPTH));
    assign empty         = (r_count == '0);
    assign count         = r_count;
    assign mem_wr_valid  = !empty;
    assign mem_wr_addr   = r_mem[r_head].addr;
    assign mem_wr_data   = r_mem[r_head].val;
    assign mem_wr_size   = r_mem[r_head].size;

    // Full comes from count alone: a pop in the same cycle does not free a slot.
    assign w_push = datafifo_valid_in && !datafifo_full;
    assign w_pop  = mem_wr_valid && mem_wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_in;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset)
        !(datafifo_valid_in && datafifo_full));

    // Candidates are laid out by age: slot k is the k-th oldest entry counted
    // from the head, slot DEPTH is the store being enqueued this cycle.
    assign w_ld_mask = sb_byte_mask(lookup_size, lookup_addr[1:0]);

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        logic [PW-1:0] w_idx;
        assign w_idx = r_head + PW'(k);
        sb_entry_match u_match (
            .i_valid     (CW'(k) < r_count),
            .i_entry     (r_mem[w_idx]),
            .i_ld_word   (lookup_addr[31:2]),
            .i_ld_mask   (w_ld_mask),
            .o_overlap   (w_ovl[k]),
            .o_cover     (w_cov[k]),
            .o_lane_data (w_lane[k])
        );
    end

    sb_entry_match u_match_in (
        .i_valid     (w_push),
        .i_entry     (w_in),
        .i_ld_word   (lookup_addr[31:2]),
        .i_ld_mask   (w_ld_mask),
        .o_overlap   (w_ovl[DEPTH]),
        .o_cover     (w_cov[DEPTH]),
        .o_lane_data (w_lane[DEPTH])
    );

    logic        w_sel_ovl, w_sel_cov;
    logic [31:0] w_sel_lane, w_size_mask;

    // Walk oldest to youngest so the last overlapping candidate wins.
    always_comb begin
        w_sel_ovl  = 1'b0;
        w_sel_cov  = 1'b0;
        w_sel_lane = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            if (w_ovl[k]) begin
                w_sel_ovl  = 1'b1;
                w_sel_cov  = w_cov[k];
                w_sel_lane = w_lane[k];
            end
        end
    end

    always_comb begin
        case (lookup_size)
            SB_SIZE_BYTE: w_size_mask = 32'h0000_00FF;
            SB_SIZE_HALF: w_size_mask = 32'h0000_FFFF;
            default:      w_size_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign lookup_hit      = lookup_valid && w_sel_ovl && FWD_EN && w_sel_cov;
    assign lookup_conflict = lookup_valid && w_sel_ovl && !(FWD_EN && w_sel_cov);
    assign lookup_data     = lookup_hit
                             ? ((w_sel_lane >> {lookup_addr[1:0], 3'b000}) & w_size_mask)
                             : 32'h0;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- DEPTH=4, forwarding on ----
    logic [31:0] a_in, v_in, m_addr, m_data, l_addr, l_data;
    logic [1:0]  s_in, m_size, l_size;
    logic        vin, full, m_valid, m_ready, l_valid, l_hit, l_conf, emp;
    logic [2:0]  cnt;

    store_buffer #(.DEPTH(4), .FWD_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .datafifo_addr_in(a_in), .datafifo_val_in(v_in), .datafifo_size_in(s_in),
        .datafifo_valid_in(vin), .datafifo_full(full),
        .mem_wr_addr(m_addr), .mem_wr_data(m_data), .mem_wr_size(m_size),
        .mem_wr_valid(m_valid), .mem_wr_ready(m_ready),
        .lookup_addr(l_addr), .lookup_size(l_size), .lookup_valid(l_valid),
        .lookup_hit(l_hit), .lookup_data(l_data), .lookup_conflict(l_conf),
        .empty(emp), .count(cnt)
    );

    // ---- DEPTH=8, forwarding on ----
    logic [31:0] a8, v8, m_addr8, m_data8, l_data8;
    logic [1:0]  s8, m_size8;
    logic        vin8, full8, m_valid8, m_ready8, l_hit8, l_conf8, emp8;
    logic [3:0]  cnt8;

    store_buffer #(.DEPTH(8), .FWD_EN(1'b1)) u_dut8 (
        .clk(clk), .reset(reset),
        .datafifo_addr_in(a8), .datafifo_val_in(v8), .datafifo_size_in(s8),
        .datafifo_valid_in(vin8), .datafifo_full(full8),
        .mem_wr_addr(m_addr8), .mem_wr_data(m_data8), .mem_wr_size(m_size8),
        .mem_wr_valid(m_valid8), .mem_wr_ready(m_ready8),
        .lookup_addr(32'h0), .lookup_size(2'd0), .lookup_valid(1'b0),
        .lookup_hit(l_hit8), .lookup_data(l_data8), .lookup_conflict(l_conf8),
        .empty(emp8), .count(cnt8)
    );

    // ---- DEPTH=4, forwarding off ----
    logic [31:0] an, vn, m_addrn, m_datan, l_addrn, l_datan;
    logic [1:0]  sn, m_sizen, l_sizen;
    logic        vinn, fulln, m_validn, l_validn, l_hitn, l_confn, empn;
    logic [2:0]  cntn;

    store_buffer #(.DEPTH(4), .FWD_EN(1'b0)) u_dutnf (
        .clk(clk), .reset(reset),
        .datafifo_addr_in(an), .datafifo_val_in(vn), .datafifo_size_in(sn),
        .datafifo_valid_in(vinn), .datafifo_full(fulln),
        .mem_wr_addr(m_addrn), .mem_wr_data(m_datan), .mem_wr_size(m_sizen),
        .mem_wr_valid(m_validn), .mem_wr_ready(1'b0),
        .lookup_addr(l_addrn), .lookup_size(l_sizen), .lookup_valid(l_validn),
        .lookup_hit(l_hitn), .lookup_data(l_datan), .lookup_conflict(l_confn),
        .empty(empn), .count(cntn)
    );

    task automatic enq(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        a_in = a; v_in = v; s_in = s; vin = 1'b1;
        tick();
        vin = 1'b0;
    endtask

    task automatic look(input logic [31:0] a, input logic [1:0] s);
        l_addr = a; l_size = s; l_valid = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_in = '0; v_in = '0; s_in = '0; vin = 1'b0; m_ready = 1'b0;
        l_addr = '0; l_size = '0; l_valid = 1'b0;
        a8 = '0; v8 = '0; s8 = '0; vin8 = 1'b0; m_ready8 = 1'b0;
        an = '0; vn = '0; sn = '0; vinn = 1'b0;
        l_addrn = '0; l_sizen = '0; l_validn = 1'b0;
        #3;
        chk("rst_empty", 32'(emp), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_mdata", m_data, 32'h0);
        chk("rst_hit", 32'(l_hit), 32'd0);
        chk("rst_conf", 32'(l_conf), 32'd0);
        chk("rst_ldata", l_data, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Fill to full, then drain in order.
        for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), SB_SIZE_WORD);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(cnt), 32'd4);
        chk("fill_empty", 32'(emp), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(m_valid), 32'd1);
            chk("drain_addr", m_addr, 32'h100 + 32'(4 * i));
            chk("drain_data", m_data, 32'hA0 + 32'(i));
            tick();
        end
        m_ready = 1'b0;
        chk("drain_empty", 32'(emp), 32'd1);
        chk("drain_mvalid", 32'(m_valid), 32'd0);

        // Youngest-first forwarding with a partial-overlap stall.
        enq(32'h200, 32'h11223344, SB_SIZE_WORD);
        enq(32'h201, 32'h000000AB, SB_SIZE_BYTE);
        look(32'h201, SB_SIZE_BYTE);
        chk("fwd_byte_hit", 32'(l_hit), 32'd1);
        chk("fwd_byte_data", l_data, 32'h000000AB);
        chk("fwd_byte_conf", 32'(l_conf), 32'd0);
        look(32'h200, SB_SIZE_WORD);
        chk("part_conf", 32'(l_conf), 32'd1);
        chk("part_hit", 32'(l_hit), 32'd0);
        chk("part_data", l_data, 32'h0);
        look(32'h203, SB_SIZE_BYTE);
        chk("old_byte_hit", 32'(l_hit), 32'd1);
        chk("old_byte_data", l_data, 32'h00000011);
        look(32'h202, SB_SIZE_HALF);
        chk("old_half_data", l_data, 32'h00001122);
        look(32'h204, SB_SIZE_WORD);
        chk("miss_hit", 32'(l_hit), 32'd0);
        chk("miss_conf", 32'(l_conf), 32'd0);
        look(32'h201, SB_SIZE_BYTE);
        l_valid = 1'b0;
        #1;
        chk("lvalid0_hit", 32'(l_hit), 32'd0);
        chk("lvalid0_data", l_data, 32'h0);

        // Forwarding from the store being enqueued this cycle.
        a_in = 32'h300; v_in = 32'hDEADBEEF; s_in = SB_SIZE_WORD; vin = 1'b1;
        look(32'h302, SB_SIZE_HALF);
        chk("inc_hit", 32'(l_hit), 32'd1);
        chk("inc_data", l_data, 32'h0000DEAD);
        tick();
        vin = 1'b0;
        l_valid = 1'b0;
        chk("inc_count", 32'(cnt), 32'd3);

        // Async reset mid-operation.
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        reset = 1'b1;
        #2;
        chk("async_count", 32'(cnt), 32'd0);
        chk("async_empty", 32'(emp), 32'd1);
        chk("async_mvalid", 32'(m_valid), 32'd0);
        chk("async_maddr", m_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // DEPTH=8 streaming: one push and one pop per cycle across pointer wrap.
        m_ready8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a8 = 32'h1000 + 32'(4 * i); v8 = 32'(i); s8 = SB_SIZE_WORD; vin8 = 1'b1;
            if (i > 0) begin
                chk("str_count", 32'(cnt8), 32'd1);
                chk("str_addr", m_addr8, 32'h1000 + 32'(4 * (i - 1)));
                chk("str_data", m_data8, 32'(i - 1));
            end
            tick();
        end
        vin8 = 1'b0;
        chk("str_last_addr", m_addr8, 32'h1000 + 32'(4 * 19));
        chk("str_last_count", 32'(cnt8), 32'd1);
        tick();
        chk("str_empty", 32'(emp8), 32'd1);

        // Forwarding disabled: any overlap stalls.
        an = 32'h400; vn = 32'h12345678; sn = SB_SIZE_WORD; vinn = 1'b1;
        tick();
        vinn = 1'b0;
        l_addrn = 32'h400; l_sizen = SB_SIZE_WORD; l_validn = 1'b1;
        #1;
        chk("nf_hit", 32'(l_hitn), 32'd0);
        chk("nf_conf", 32'(l_confn), 32'd1);
        chk("nf_data", l_datan, 32'h0);
        l_addrn = 32'h404;
        #1;
        chk("nf_miss_conf", 32'(l_confn), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
